// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: result sources,
// forward selects and the data-memory wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } res_src_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MW_IDLE = 1'b0,
    MW_WAIT = 1'b1
  } mw_state_t;

  // Memory stage wins over write-back; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       wr_m,
                                          input logic [4:0] rd_w,
                                          input logic       wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return FWD_MEM;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_memwait.sv
// Data-memory wait state machine with timeout counter and sticky error flag.
module hazard_memwait
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_access,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_err
);

  localparam int unsigned TW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  mw_state_t         state, state_nxt;
  logic [TW-1:0]     wait_cnt, wait_cnt_nxt;
  logic              err_nxt;

  assign mem_stall = mem_access & ~mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MW_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= err_nxt;
    end
  end

  // The count stops at MEM_TIMEOUT; the FSM itself never leaves WAIT on timeout.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = mem_err;
    unique case (state)
      MW_IDLE: begin
        if (mem_stall) begin
          state_nxt    = MW_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MW_WAIT: begin
        if (mem_ready) begin
          state_nxt = MW_IDLE;
        end else if (wait_cnt != TW'(MEM_TIMEOUT)) begin
          wait_cnt_nxt = wait_cnt + TW'(1);
          if (wait_cnt_nxt == TW'(MEM_TIMEOUT))
            err_nxt = 1'b1;
        end
      end
      default: state_nxt = MW_IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow E/M/W state, operand forwarding,
// load-use / branch / memory-wait stall and flush control, event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemAccessD,
  input  logic             PCSrcE,
  input  logic             DMemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);

  logic [4:0] rs1_e, rs2_e, rd_e;
  logic       reg_write_e, mem_access_e;
  logic [1:0] res_src_e;
  logic [4:0] rd_m;
  logic       reg_write_m, mem_access_m;
  logic [4:0] rd_w;
  logic       reg_write_w;

  logic mem_stall;
  logic lw_stall;
  logic lw_act;
  logic br_act;

  hazard_memwait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_memwait (
    .clk        (clk),
    .reset      (reset),
    .mem_access (mem_access_m),
    .mem_ready  (DMemReadyM),
    .mem_stall  (mem_stall),
    .mem_err    (MemErr)
  );

  assign lw_stall = (res_src_e == RES_LOAD) && (rd_e != 5'd0) &&
                    ((rd_e == Rs1D) || (rd_e == Rs2D));
  // A memory wait masks everything; a taken branch overrides a load-use stall.
  assign br_act   = PCSrcE & ~mem_stall;
  assign lw_act   = lw_stall & ~PCSrcE & ~mem_stall;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      ForwardAE = fwd_select(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      ForwardBE = fwd_select(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (br_act) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_act) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      reg_write_e  <= 1'b0;
      res_src_e    <= '0;
      mem_access_e <= 1'b0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_access_m <= 1'b0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
    end else begin
      if (!StallE) begin
        if (FlushE) begin
          rs1_e        <= '0;
          rs2_e        <= '0;
          rd_e         <= '0;
          reg_write_e  <= 1'b0;
          res_src_e    <= '0;
          mem_access_e <= 1'b0;
        end else begin
          rs1_e        <= Rs1D;
          rs2_e        <= Rs2D;
          rd_e         <= RdD;
          reg_write_e  <= RegWriteD;
          res_src_e    <= ResultSrcD;
          mem_access_e <= MemAccessD;
        end
      end
      if (!StallM) begin
        rd_m         <= rd_e;
        reg_write_m  <= reg_write_e;
        mem_access_m <= mem_access_e;
      end
      if (FlushW) begin
        rd_w        <= '0;
        reg_write_w <= 1'b0;
      end else begin
        rd_w        <= rd_m;
        reg_write_w <= reg_write_m;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LoadUseCnt <= '0;
      FlushCnt   <= '0;
      MemWaitCnt <= '0;
    end else begin
      if (lw_act && (LoadUseCnt != '1))
        LoadUseCnt <= LoadUseCnt + CNT_W'(1);
      if (br_act && (FlushCnt != '1))
        FlushCnt <= FlushCnt + CNT_W'(1);
      if (mem_stall && (MemWaitCnt != '1))
        MemWaitCnt <= MemWaitCnt + CNT_W'(1);
    end
  end

endmodule
